// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N requesters, one grant per packet or MAX_BURST beats
module fifo_wr_arbiter #(
   parameter int N         = 4,
   parameter int WIDTH_D   = 16,
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 16
) (
   input  logic                   w_clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           req_valid,
   input  logic [N-1:0]           req_last,
   input  logic [N*WIDTH_D-1:0]   req_data,
   output logic [N-1:0]           req_ready,
   input  logic                   w_full,
   output logic                   w_req,
   output logic [WIDTH_D-1:0]     w_data,
   output logic                   gnt_valid,
   output logic [$clog2(N)-1:0]   gnt_id,
   output logic [CNT_W-1:0]       beat_cnt
);
   localparam int IDW = $clog2(N);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state_q, state_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d, last_gnt_q, last_gnt_d, pick, idx;
   logic [7:0] burst_q, burst_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [WIDTH_D-1:0] slot [N];
   logic found, accept, rel;
   always_comb begin
      found = 1'b0;
      pick = last_gnt_q;
      idx = last_gnt_q;
      for (int k = 1; k <= N; k++) begin
         idx = IDW'((int'(last_gnt_q) + k) % N);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick = idx;
         end
      end
   end
   always_comb begin
      for (int i = 0; i < N; i++) slot[i] = req_data[i*WIDTH_D +: WIDTH_D];
   end
   assign accept    = (state_q == GRANT) && req_valid[gnt_id_q] && !w_full;
   assign rel       = accept && (req_last[gnt_id_q] || burst_q == 8'(MAX_BURST - 1));
   assign gnt_valid = (state_q == GRANT);
   assign gnt_id    = gnt_id_q;
   assign beat_cnt  = beat_cnt_q;
   assign w_req     = accept;
   assign w_data    = (state_q == GRANT) ? slot[gnt_id_q] : '0;
   assign req_ready = (state_q == GRANT && !w_full) ? N'(1) << gnt_id_q : '0;
   always_comb begin
      state_d    = state_q;
      gnt_id_d   = gnt_id_q;
      last_gnt_d = last_gnt_q;
      burst_d    = burst_q;
      beat_cnt_d = beat_cnt_q + CNT_W'(accept);
      if (state_q == IDLE) begin
         if (found) begin
            state_d    = GRANT;
            gnt_id_d   = pick;
            last_gnt_d = pick;
            burst_d    = '0;
         end
      end else if (accept) begin
         burst_d = burst_q + 8'd1;
         state_d = rel ? IDLE : GRANT;
      end
   end
   // last_gnt resets to N-1 so the first search starts at requester 0
   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_id_q   <= '0;
         last_gnt_q <= IDW'(N - 1);
         burst_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_id_q   <= gnt_id_d;
         last_gnt_q <= last_gnt_d;
         burst_q    <= burst_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed table vectors plus hand-written multi-cycle sequences for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   logic w_clk = 1'b0, rst_n = 1'b0, w_full = 1'b0;
   logic [3:0] req_valid = '0, req_last = '0, req_ready;
   logic [63:0] req_data = '0;
   logic w_req, gnt_valid;
   logic [15:0] w_data, beat_cnt;
   logic [1:0] gnt_id;
   int n_chk = 0, n_fail = 0;
   int ptr [4];

   fifo_wr_arbiter dut (
      .w_clk(w_clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_ready(req_ready), .w_full(w_full), .w_req(w_req),
      .w_data(w_data), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .beat_cnt(beat_cnt)
   );

   always #5 w_clk = ~w_clk;

   typedef struct packed {
      logic [3:0] v, l; logic [15:0] d; logic f;
      logic wr; logic [15:0] wd; logic gv; logic [1:0] id; logic [3:0] rdy; logic [15:0] bc;
   } vec_t;
   vec_t tbl [$];

   function automatic vec_t mk(logic [3:0] v, l, logic [15:0] d, logic f, logic wr,
                               logic [15:0] wd, logic gv, logic [1:0] id, logic [3:0] rdy, logic [15:0] bc);
      mk = '{v, l, d, f, wr, wd, gv, id, rdy, bc};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; w_full = 1'b0;
      repeat (2) @(posedge w_clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) ptr[i] = 0;
   endtask

   task automatic run_table(input string tag);
      foreach (tbl[r]) begin
         req_valid = tbl[r].v; req_last = tbl[r].l; req_data = {4{tbl[r].d}}; w_full = tbl[r].f;
         @(negedge w_clk);
         check($sformatf("%s r%0d w_req", tag, r), 32'(w_req), 32'(tbl[r].wr));
         check($sformatf("%s r%0d w_data", tag, r), 32'(w_data), 32'(tbl[r].wd));
         check($sformatf("%s r%0d gnt_valid", tag, r), 32'(gnt_valid), 32'(tbl[r].gv));
         check($sformatf("%s r%0d gnt_id", tag, r), 32'(gnt_id), 32'(tbl[r].id));
         check($sformatf("%s r%0d req_ready", tag, r), 32'(req_ready), 32'(tbl[r].rdy));
         check($sformatf("%s r%0d beat_cnt", tag, r), 32'(beat_cnt), 32'(tbl[r].bc));
         @(posedge w_clk); #1;
      end
      tbl.delete();
   endtask

   // each requester sends {id, sequence number}; pktlen 0 means never last
   task automatic drive(input logic [3:0] mask, input int pktlen);
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = mask[i];
         req_data[i*16 +: 16] = {8'(i), 8'(ptr[i])};
         req_last[i] = (pktlen != 0) && (ptr[i] % pktlen == pktlen - 1);
      end
   endtask

   task automatic advance();
      for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) ptr[i]++;
      @(posedge w_clk); #1;
   endtask

   initial begin
      int n, acc;
      do_reset();
      @(negedge w_clk);
      check("reset gnt_valid", 32'(gnt_valid), 32'h0);
      check("reset req_ready", 32'(req_ready), 32'h0);
      check("reset beat_cnt", 32'(beat_cnt), 32'h0);
      @(posedge w_clk); #1;

      // single 3-beat packet from requester 0
      do_reset();
      tbl.push_back(mk(4'b0001, 4'b0000, 16'h0011, 0, 0, 16'h0000, 0, 0, 4'b0000, 0));
      tbl.push_back(mk(4'b0001, 4'b0000, 16'h0011, 0, 1, 16'h0011, 1, 0, 4'b0001, 0));
      tbl.push_back(mk(4'b0001, 4'b0000, 16'h0022, 0, 1, 16'h0022, 1, 0, 4'b0001, 1));
      tbl.push_back(mk(4'b0001, 4'b0001, 16'h0033, 0, 1, 16'h0033, 1, 0, 4'b0001, 2));
      tbl.push_back(mk(4'b0000, 4'b0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 4'b0000, 3));
      run_table("pkt3");

      // w_full stall mid-packet on requester 1
      do_reset();
      tbl.push_back(mk(4'b0010, 4'b0000, 16'h1000, 0, 0, 16'h0000, 0, 0, 4'b0000, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 16'h1000, 0, 1, 16'h1000, 1, 1, 4'b0010, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 16'h1001, 0, 1, 16'h1001, 1, 1, 4'b0010, 1));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(4'b0010, 4'b0000, 16'h1002, 1, 0, 16'h1002, 1, 1, 4'b0000, 2));
      tbl.push_back(mk(4'b0010, 4'b0000, 16'h1002, 0, 1, 16'h1002, 1, 1, 4'b0010, 2));
      tbl.push_back(mk(4'b0010, 4'b0010, 16'h1003, 0, 1, 16'h1003, 1, 1, 4'b0010, 3));
      tbl.push_back(mk(4'b0000, 4'b0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 4'b0000, 4));
      run_table("stall");

      // requesters 0,1,2 with 2-beat packets: order 0,1,2,0,1,2 with one bubble each
      do_reset();
      for (int c = 0; c < 18; c++) begin
         drive(4'b0111, 2);
         @(negedge w_clk);
         check($sformatf("rr c%0d w_req", c), 32'(w_req), 32'(c % 3 != 0));
         if (c % 3 != 0) begin
            check($sformatf("rr c%0d gnt_id", c), 32'(gnt_id), 32'((c / 3) % 3));
            check($sformatf("rr c%0d w_data", c), 32'(w_data),
                  32'({8'((c / 3) % 3), 8'((c / 9) * 2 + c % 3 - 1)}));
            check($sformatf("rr c%0d req_ready", c), 32'(req_ready), 32'(1 << ((c / 3) % 3)));
         end else
            check($sformatf("rr c%0d req_ready", c), 32'(req_ready), 32'h0);
         advance();
      end

      // requester 3 streaming without last: 16 beats, bubble, 16 more
      do_reset();
      for (int c = 0; c < 34; c++) begin
         drive(4'b1000, 0);
         @(negedge w_clk);
         check($sformatf("burst c%0d w_req", c), 32'(w_req), 32'(c % 17 != 0));
         if (c % 17 != 0) begin
            check($sformatf("burst c%0d gnt_id", c), 32'(gnt_id), 32'h3);
            check($sformatf("burst c%0d w_data", c), 32'(w_data), 32'({8'h03, 8'(c - c / 17 - 1)}));
         end
         advance();
      end

      // asynchronous reset after beat 2 of 4 from requester 2
      do_reset();
      acc = 0;
      req_valid = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         req_data = {4{16'(16'h2000 + acc)}};
         @(negedge w_clk);
         if (w_req) acc++;
         @(posedge w_clk); #1;
      end
      check("arst beats before", 32'(acc), 32'd2);
      req_data = {4{16'h2002}};
      check("arst w_req pre", 32'(w_req), 32'h1);
      rst_n = 1'b0;
      #1;
      check("arst gnt_valid", 32'(gnt_valid), 32'h0);
      check("arst req_ready", 32'(req_ready), 32'h0);
      check("arst w_req", 32'(w_req), 32'h0);
      check("arst w_data", 32'(w_data), 32'h0);
      check("arst beat_cnt", 32'(beat_cnt), 32'h0);
      req_valid = 4'b1001;
      @(negedge w_clk);
      rst_n = 1'b1;
      @(posedge w_clk); #1;
      @(negedge w_clk);
      check("arst regrant valid", 32'(gnt_valid), 32'h1);
      check("arst regrant id", 32'(gnt_id), 32'h0);
      @(posedge w_clk); #1;

      // beat_cnt wrap after 65535 + 1 beats
      do_reset();
      req_valid = 4'b0001;
      n = 0;
      for (int c = 0; c < 80000 && n < 65535; c++) begin
         @(negedge w_clk);
         if (w_req) n++;
         @(posedge w_clk); #1;
      end
      check("wrap beats streamed", 32'(n), 32'd65535);
      req_valid = 4'b0000;
      @(negedge w_clk);
      check("wrap beat_cnt max", 32'(beat_cnt), 32'hffff);
      @(posedge w_clk); #1;
      req_valid = 4'b0001;
      @(negedge w_clk);
      check("wrap last w_req", 32'(w_req), 32'h1);
      @(posedge w_clk); #1;
      req_valid = 4'b0000;
      @(negedge w_clk);
      check("wrap beat_cnt zero", 32'(beat_cnt), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
